// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that serialises single-byte producer messages into the UART TX FIFO.
// Optional idle keepalive injection is compiled in with `define UART_KEEPALIVE_EN.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 16
`ifdef UART_KEEPALIVE_EN
  ,
  parameter int         KEEPALIVE_CYCLES = 1_000_000,
  parameter logic [7:0] KEEPALIVE_BYTE   = 8'h00
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [8*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]     ch_ack,
  input  logic                  tx_full,
  output logic [7:0]            w_data,
  output logic                  wr_uart,
  output logic                  busy,
  output logic [NUM_CH-1:0]     overrun
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WRITE, GAP} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] pending;
  logic [7:0]        hold [NUM_CH];
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     grant_idx;
  logic [GW-1:0]     cand;
  logic              grant_en;
  logic [7:0]        out_reg;
  logic [7:0]        gap_cnt;
  logic              ka_fire;
  logic              ka_flag;
  logic              write_now;

  // Search order starts just after the previous winner; the loop runs far-to-near
  // so the nearest pending channel is the last one assigned.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_CH);
      if (pending[cand]) grant_idx = cand;
    end
  end

  assign grant_en  = (state == IDLE) && (|pending);
  assign write_now = (state == SEND) && !tx_full;
  assign busy      = (state != IDLE) || (|pending);

`ifdef UART_KEEPALIVE_EN
  logic [31:0] idle_cnt;

  // A request in the expiry cycle suppresses the keepalive so the channel wins next cycle.
  assign ka_fire = (state == IDLE) && !(|pending) && !(|ch_req) &&
                   (idle_cnt == 32'(KEEPALIVE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || wr_uart || (|ch_req) || ka_fire) begin
      idle_cnt <= '0;
    end else if ((state == IDLE) && !(|pending)) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign ka_fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_en || ka_fire) state_nxt = SEND;
      SEND:    if (!tx_full) state_nxt = WRITE;
      WRITE:   state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt <= 8'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_CH - 1);
      out_reg    <= '0;
      ka_flag    <= 1'b0;
      gap_cnt    <= '0;
      wr_uart    <= 1'b0;
      w_data     <= '0;
      ch_ack     <= '0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        out_reg    <= hold[grant_idx];
        last_grant <= grant_idx;
        ka_flag    <= 1'b0;
      end
`ifdef UART_KEEPALIVE_EN
      else if (ka_fire) begin
        out_reg <= KEEPALIVE_BYTE;
        ka_flag <= 1'b1;
      end
`endif
      if (state == WRITE) begin
        gap_cnt <= 8'(GAP_CYCLES);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
      wr_uart <= write_now;
      ch_ack  <= (write_now && !ka_flag) ? (NUM_CH'(1) << last_grant) : '0;
      if (write_now) w_data <= out_reg;
    end
  end

  // A grant on the same edge as a new request ships the old byte and keeps the new one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_req[i]) begin
          pending[i] <= 1'b1;
          hold[i]    <= ch_data[8*i +: 8];
          if (pending[i] && !(grant_en && (grant_idx == GW'(i)))) overrun[i] <= 1'b1;
        end else if (grant_en && (grant_idx == GW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule
